// File: rtl/axi_mem_responder_if.sv
// axi_mem_responder_if: AXI4 five-channel bundle between a master and the memory responder.
// Ports: none beyond the bundled signals; widths are set by ADDR/DATA/ID/USER_WIDTH.
// Modports: master drives AW/W/AR and B/R ready; slave drives the ready/response side.
interface axi_mem_responder_if #(
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 5,
  parameter int USER_WIDTH = 5
);
  // write address
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [ID_WIDTH-1:0]     awid;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [3:0]              awcache;
  logic                    awlock;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [3:0]              awregion;
  logic [USER_WIDTH-1:0]   awuser;
  logic                    awvalid;
  logic                    awready;
  // write data
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic [USER_WIDTH-1:0]   wuser;
  logic                    wvalid;
  logic                    wready;
  // write response
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic [USER_WIDTH-1:0]   buser;
  logic                    bvalid;
  logic                    bready;
  // read address
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [ID_WIDTH-1:0]     arid;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [3:0]              arcache;
  logic                    arlock;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [3:0]              arregion;
  logic [USER_WIDTH-1:0]   aruser;
  logic                    arvalid;
  logic                    arready;
  // read data
  logic [DATA_WIDTH-1:0]   rdata;
  logic [ID_WIDTH-1:0]     rid;
  logic [1:0]              rresp;
  logic                    rlast;
  logic [USER_WIDTH-1:0]   ruser;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awid, awlen, awsize, awburst, awcache, awlock, awprot, awqos, awregion,
           awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready,
    output araddr, arid, arlen, arsize, arburst, arcache, arlock, arprot, arqos, arregion,
           aruser, arvalid,
    input  arready,
    input  rdata, rid, rresp, rlast, ruser, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awid, awlen, awsize, awburst, awcache, awlock, awprot, awqos, awregion,
           awuser, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready,
    input  araddr, arid, arlen, arsize, arburst, arcache, arlock, arprot, arqos, arregion,
           aruser, arvalid,
    output arready,
    output rdata, rid, rresp, rlast, ruser, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave endpoint backed by an on-chip MEM_DEPTH x DATA_WIDTH memory.
// Latency: AW->wready 1 cycle, last W->bvalid 1 cycle; AR->rvalid 2 cycles, 1 read beat per 2 cycles.
// Backpressure: B and R outputs held stable until bready/rready; one burst in flight per channel.
// Ports: clk, arst (async, active-high), bus (slave modport of axi_mem_responder_if).
// Option: define AXI_RESP_USER_EN to echo awuser on buser and aruser on ruser; otherwise both are 0.
module axi_mem_responder #(
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 5,
  parameter int USER_WIDTH = 5,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic               clk,
  input  logic               arst,
  axi_mem_responder_if.slave bus
);
  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int IDX_LSB = $clog2(STRB_W);
  localparam int IDX_W   = $clog2(MEM_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // ---------------- write channel ----------------
  w_state_t            w_state, w_next;
  logic [IDX_W-1:0]    w_idx;
  logic [ID_WIDTH-1:0] w_id;
  logic [7:0]          w_len, w_cnt;
  logic [1:0]          w_burst;
  logic                w_err;

  logic aw_hs, w_hs, b_hs, w_on_last, w_err_n;
  logic awready_d, wready_d, bvalid_d;
  logic [ID_WIDTH-1:0]   bid_d;
  logic [1:0]            bresp_d;
  logic [USER_WIDTH-1:0] buser_d;

  assign aw_hs     = bus.awvalid & bus.awready;
  assign w_hs      = bus.wvalid & bus.wready;
  assign b_hs      = bus.bvalid & bus.bready;
  assign w_on_last = (w_cnt == w_len);
  // wlast disagreeing with the awlen beat count poisons the response but never ends the burst
  assign w_err_n   = w_err | (w_hs & (bus.wlast != w_on_last));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      w_state     <= W_IDLE;
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bid     <= '0;
      bus.bresp   <= RESP_OKAY;
      bus.buser   <= '0;
    end else begin
      w_state     <= w_next;
      bus.awready <= awready_d;
      bus.wready  <= wready_d;
      bus.bvalid  <= bvalid_d;
      bus.bid     <= bid_d;
      bus.bresp   <= bresp_d;
      bus.buser   <= buser_d;
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_on_last) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change with the state.
  always_comb begin
    awready_d = (w_next == W_IDLE);
    wready_d  = (w_next == W_DATA);
    bvalid_d  = (w_next == W_RESP);
    bid_d     = bvalid_d ? w_id : '0;
    bresp_d   = (bvalid_d && w_err_n) ? RESP_SLVERR : RESP_OKAY;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      w_idx   <= '0;
      w_id    <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_idx   <= bus.awaddr[IDX_LSB +: IDX_W];
      w_id    <= bus.awid;
      w_len   <= bus.awlen;
      w_cnt   <= '0;
      w_burst <= bus.awburst;
      w_err   <= (bus.awburst == BURST_RSVD);
    end else if (w_hs) begin
      w_cnt <= w_cnt + 8'd1;
      w_err <= w_err_n;
      if (w_burst != BURST_FIXED) w_idx <= w_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (bus.wstrb[b]) mem[w_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t            r_state, r_next;
  logic [IDX_W-1:0]    r_idx;
  logic [ID_WIDTH-1:0] r_id;
  logic [7:0]          r_len, r_cnt;
  logic [1:0]          r_burst;

  logic ar_hs, r_hs, r_on_last;
  logic arready_d, rvalid_d, rlast_d;
  logic [ID_WIDTH-1:0]   rid_d;
  logic [1:0]            rresp_d;
  logic [USER_WIDTH-1:0] ruser_d;

  assign ar_hs     = bus.arvalid & bus.arready;
  assign r_hs      = bus.rvalid & bus.rready;
  assign r_on_last = (r_cnt == r_len);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state     <= R_IDLE;
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rid     <= '0;
      bus.rresp   <= RESP_OKAY;
      bus.rlast   <= 1'b0;
      bus.ruser   <= '0;
    end else begin
      r_state     <= r_next;
      bus.arready <= arready_d;
      bus.rvalid  <= rvalid_d;
      bus.rid     <= rid_d;
      bus.rresp   <= rresp_d;
      bus.rlast   <= rlast_d;
      bus.ruser   <= ruser_d;
    end
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_FETCH;
      R_FETCH: r_next = R_DATA;
      R_DATA:  if (r_hs) r_next = r_on_last ? R_IDLE : R_FETCH;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    arready_d = (r_next == R_IDLE);
    rvalid_d  = (r_next == R_DATA);
    rid_d     = rvalid_d ? r_id : '0;
    rresp_d   = (rvalid_d && r_burst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
    rlast_d   = rvalid_d & r_on_last;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_idx   <= '0;
      r_id    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= '0;
    end else if (ar_hs) begin
      r_idx   <= bus.araddr[IDX_LSB +: IDX_W];
      r_id    <= bus.arid;
      r_len   <= bus.arlen;
      r_cnt   <= '0;
      r_burst <= bus.arburst;
    end else if (r_hs && !r_on_last) begin
      r_cnt <= r_cnt + 8'd1;
      if (r_burst != BURST_FIXED) r_idx <= r_idx + IDX_W'(1);
    end
  end

  // Registered read port; sampling before the write NBA lands gives read-first behaviour.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)                    bus.rdata <= '0;
    else if (r_state == R_FETCH) bus.rdata <= mem[r_idx];
  end

  // ---------------- user sideband ----------------
`ifdef AXI_RESP_USER_EN
  logic [USER_WIDTH-1:0] w_user, r_user;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      w_user <= '0;
      r_user <= '0;
    end else begin
      if (aw_hs) w_user <= bus.awuser;
      if (ar_hs) r_user <= bus.aruser;
    end
  end

  assign buser_d = bvalid_d ? w_user : '0;
  assign ruser_d = rvalid_d ? r_user : '0;
`else
  assign buser_d = '0;
  assign ruser_d = '0;
`endif

  // Sideband fields the memory model has no use for.
  logic unused_ok;
  assign unused_ok = ^{bus.awsize, bus.awcache, bus.awlock, bus.awprot, bus.awqos, bus.awregion,
                       bus.arsize, bus.arcache, bus.arlock, bus.arprot, bus.arqos, bus.arregion,
                       bus.wuser, bus.awaddr, bus.araddr
`ifndef AXI_RESP_USER_EN
                       , bus.awuser, bus.aruser
`endif
                       };
endmodule

// File: tb/tb_axi_mem_responder.sv
module tb_axi_mem_responder;
  localparam int AW = 33, DW = 256, IW = 5, UW = 5, DEPTH = 1024, NB = DW / 8;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  axi_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW)) bus ();

  axi_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW),
                      .MEM_DEPTH(DEPTH)) dut (.clk(clk), .arst(arst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // lo/hi: per-beat byte values (beat b in bits [8b+7:8b]); expected word is
  // 28 copies of the hi byte over 4 copies of the lo byte.
  typedef struct {
    bit          wr;
    logic [32:0] addr;
    logic [4:0]  id;
    logic [7:0]  len;
    logic [1:0]  burst;
    int          wlast_at;
    int          pbeat;
    logic [31:0] pstrb;
    logic [7:0]  seed;
    logic [1:0]  resp;
    logic [31:0] lo;
    logic [31:0] hi;
    int          stall;
  } vec_t;

  vec_t tbl[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input logic [7:0] lo, input logic [7:0] hi);
    return {{28{hi}}, {4{lo}}};
  endfunction

  function automatic logic [UW-1:0] exp_user(input logic [UW-1:0] u);
`ifdef AXI_RESP_USER_EN
    return u;
`else
    return '0;
`endif
  endfunction

  task automatic do_write(input vec_t v, input string nm);
    int t, waits;
    logic [7:0] bv;
    bus.awaddr  = v.addr;
    bus.awid    = v.id;
    bus.awlen   = v.len;
    bus.awburst = v.burst;
    bus.awuser  = v.id ^ 5'h15;
    bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < 50) begin step(); t++; end
    chk({nm, "_aw_ready"}, bus.awready, 1'b1);
    step();
    bus.awvalid = 1'b0;
    waits = 0;
    for (int b = 0; b <= int'(v.len); b++) begin
      bv = v.seed + 8'(b);
      bus.wdata  = {NB{bv}};
      bus.wstrb  = (b == v.pbeat) ? v.pstrb : '1;
      bus.wlast  = (b == v.wlast_at);
      bus.wvalid = 1'b1;
      t = 0;
      while (!bus.wready && t < 50) begin step(); t++; waits++; end
      step();
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    chk({nm, "_w_stalls"}, waits, 0);
    chk({nm, "_bvalid_wready"}, {bus.bvalid, bus.wready}, 2'b10);
    chk({nm, "_bresp"}, bus.bresp, v.resp);
    chk({nm, "_bid"}, bus.bid, v.id);
    chk({nm, "_buser"}, bus.buser, exp_user(v.id ^ 5'h15));
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    chk({nm, "_awready_after_b"}, {bus.awready, bus.bvalid}, 2'b10);
  endtask

  task automatic do_read(input vec_t v, input string nm);
    int t;
    logic [DW-1:0] ew;
    bus.araddr  = v.addr;
    bus.arid    = v.id;
    bus.arlen   = v.len;
    bus.arburst = v.burst;
    bus.aruser  = v.id ^ 5'h0A;
    bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < 50) begin step(); t++; end
    chk({nm, "_ar_ready"}, bus.arready, 1'b1);
    step();
    bus.arvalid = 1'b0;
    for (int b = 0; b <= int'(v.len); b++) begin
      string bn;
      bn = $sformatf("%s_b%0d", nm, b);
      // one cycle already elapsed since the handshake, rvalid due on the next
      t = 0;
      while (!bus.rvalid && t < 50) begin step(); t++; end
      chk({bn, "_latency"}, t, 1);
      ew = word(v.lo[8*b +: 8], v.hi[8*b +: 8]);
      chk({bn, "_rdata"}, bus.rdata, ew);
      chk({bn, "_rid_rresp_rlast"}, {bus.rid, bus.rresp, bus.rlast},
          {v.id, v.resp, (b == int'(v.len))});
      chk({bn, "_ruser"}, bus.ruser, exp_user(v.id ^ 5'h0A));
      if (b == v.stall) begin
        repeat (5) step();
        chk({bn, "_stall_data"}, bus.rdata, ew);
        chk({bn, "_stall_ctrl"}, {bus.rvalid, bus.rid, bus.rlast},
            {1'b1, v.id, (b == int'(v.len))});
      end
      bus.rready = 1'b1;
      step();
      bus.rready = 1'b0;
      chk({bn, "_rvalid_drop"}, bus.rvalid, 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    arst = 1'b1;
    bus.awaddr = '0; bus.awid = '0; bus.awlen = '0; bus.awsize = 3'd5; bus.awburst = 2'b01;
    bus.awcache = '0; bus.awlock = 1'b0; bus.awprot = '0; bus.awqos = '0; bus.awregion = '0;
    bus.awuser = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wuser = 5'h1F; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arid = '0; bus.arlen = '0; bus.arsize = 3'd5; bus.arburst = 2'b01;
    bus.arcache = '0; bus.arlock = 1'b0; bus.arprot = '0; bus.arqos = '0; bus.arregion = '0;
    bus.aruser = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    //        wr   addr            id     len   burst  wl  pb  pstrb          seed   resp   lo             hi           stall
    tbl.push_back('{1'b1, 33'h40,         5'd3,  8'd0, 2'b01, 0,  -1, 32'h0,        8'hA5, 2'b00, 32'h0,         32'h0,         -1});
    tbl.push_back('{1'b0, 33'h40,         5'd4,  8'd0, 2'b01, 0,  -1, 32'h0,        8'h00, 2'b00, 32'h000000A5,  32'h000000A5,  -1});
    tbl.push_back('{1'b1, 33'hE0,         5'd5,  8'd0, 2'b01, 0,  -1, 32'h0,        8'h11, 2'b00, 32'h0,         32'h0,         -1});
    tbl.push_back('{1'b1, 33'hA0,         5'd6,  8'd3, 2'b01, 3,  2,  32'h0000000F, 8'h20, 2'b00, 32'h0,         32'h0,         -1});
    tbl.push_back('{1'b0, 33'hA0,         5'd7,  8'd3, 2'b01, 0,  -1, 32'h0,        8'h00, 2'b00, 32'h23222120,  32'h23112120,  1});
    tbl.push_back('{1'b1, 33'h100,        5'd8,  8'd2, 2'b01, 1,  -1, 32'h0,        8'h40, 2'b10, 32'h0,         32'h0,         -1});
    tbl.push_back('{1'b0, 33'h100,        5'd9,  8'd2, 2'b01, 0,  -1, 32'h0,        8'h00, 2'b00, 32'h00424140,  32'h00424140,  -1});
    tbl.push_back('{1'b1, 33'h7FE0,       5'd10, 8'd1, 2'b01, 1,  -1, 32'h0,        8'h60, 2'b00, 32'h0,         32'h0,         -1});
    tbl.push_back('{1'b0, 33'h7FE0,       5'd11, 8'd1, 2'b01, 0,  -1, 32'h0,        8'h00, 2'b00, 32'h00006160,  32'h00006160,  -1});
    tbl.push_back('{1'b0, 33'h1_0000_0047, 5'd12, 8'd0, 2'b01, 0, -1, 32'h0,        8'h00, 2'b00, 32'h000000A5,  32'h000000A5,  -1});
    tbl.push_back('{1'b1, 33'h180,        5'd13, 8'd3, 2'b00, 3,  -1, 32'h0,        8'h70, 2'b00, 32'h0,         32'h0,         -1});
    tbl.push_back('{1'b0, 33'h180,        5'd14, 8'd1, 2'b00, 0,  -1, 32'h0,        8'h00, 2'b00, 32'h00007373,  32'h00007373,  -1});
    tbl.push_back('{1'b1, 33'h200,        5'd15, 8'd0, 2'b11, 0,  -1, 32'h0,        8'h90, 2'b10, 32'h0,         32'h0,         -1});
    tbl.push_back('{1'b0, 33'h200,        5'd16, 8'd0, 2'b11, 0,  -1, 32'h0,        8'h00, 2'b10, 32'h00000090,  32'h00000090,  -1});
    tbl.push_back('{1'b1, 33'h220,        5'd17, 8'd1, 2'b01, -1, -1, 32'h0,        8'hB0, 2'b10, 32'h0,         32'h0,         -1});
    tbl.push_back('{1'b0, 33'h220,        5'd18, 8'd1, 2'b01, 0,  -1, 32'h0,        8'h00, 2'b00, 32'h0000B1B0,  32'h0000B1B0,  -1});

    // reset state
    repeat (3) step();
    chk("reset_ctrl", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.bid,
                       bus.bresp, bus.buser, bus.rid, bus.rresp, bus.rlast, bus.ruser}, '0);
    chk("reset_rdata", bus.rdata, '0);
    arst = 1'b0;
    #1;
    chk("ready_before_first_edge", {bus.awready, bus.arready}, 2'b00);
    step();
    chk("ready_after_first_edge", {bus.awready, bus.arready}, 2'b11);

    foreach (tbl[i]) begin
      if (tbl[i].wr) do_write(tbl[i], $sformatf("v%0d_wr", i));
      else           do_read(tbl[i], $sformatf("v%0d_rd", i));
    end

    // reset in the middle of a write burst
    bus.awaddr = 33'h280; bus.awid = 5'd1; bus.awlen = 8'd3; bus.awburst = 2'b01;
    bus.awvalid = 1'b1;
    step();
    bus.awvalid = 1'b0;
    bus.wdata = {NB{8'hEE}}; bus.wstrb = '1; bus.wvalid = 1'b1;
    step();
    step();
    chk("midwr_in_data", bus.wready, 1'b1);
    #2 arst = 1'b1;
    #1;
    chk("midwr_reset_ctrl", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid,
                             bus.bid, bus.bresp, bus.buser, bus.rid, bus.rresp, bus.rlast,
                             bus.ruser}, '0);
    chk("midwr_reset_rdata", bus.rdata, '0);
    step();
    step();
    bus.wvalid = 1'b0;
    arst = 1'b0;
    step();
    chk("midwr_release", {bus.awready, bus.wready, bus.bvalid, bus.arready}, 4'b1001);

    v = '{1'b0, 33'h40, 5'd20, 8'd0, 2'b01, 0, -1, 32'h0, 8'h00, 2'b00, 32'h000000A5, 32'h000000A5, -1};
    do_read(v, "post_rst_w2");
    v = '{1'b0, 33'hE0, 5'd21, 8'd0, 2'b01, 0, -1, 32'h0, 8'h00, 2'b00, 32'h00000022, 32'h00000011, -1};
    do_read(v, "post_rst_w7");
    v = '{1'b1, 33'h280, 5'd22, 8'd0, 2'b01, 0, -1, 32'h0, 8'h5C, 2'b00, 32'h0, 32'h0, -1};
    do_write(v, "post_rst_wr");
    v = '{1'b0, 33'h280, 5'd23, 8'd0, 2'b01, 0, -1, 32'h0, 8'h00, 2'b00, 32'h0000005C, 32'h0000005C, -1};
    do_read(v, "post_rst_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
